// File: rtl/pipe_ctrl.sv
// Pipeline sequencer for the 5-stage core: per-stage stall vector, one-cycle flush with
// redirect PC, EX-stall watchdog and a saturating stall-cycle counter.
module pipe_ctrl #(
    parameter int unsigned MAX_STALL = 64,
    parameter int unsigned CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallreq_id,
    input  logic             stallreq_ex,
    input  logic             excp_req,
    input  logic [31:0]      excp_pc,
    output logic [5:0]       stall,
    output logic             flush,
    output logic [31:0]      new_pc,
    output logic             stall_timeout,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int unsigned WAIT_W = $clog2(MAX_STALL + 1);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        EX_WAIT = 2'd1,
        FLUSH   = 2'd2
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              wait_inc_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= next_state;
        end
    end

    // Next state plus same-cycle stall vector; an exception or flush cycle never holds.
    always_comb begin
        next_state = RUN;
        stall      = 6'b000000;
        wait_inc_c = 1'b0;

        if (excp_req) begin
            next_state = FLUSH;
        end else if (stallreq_ex && (state != FLUSH)) begin
            next_state = EX_WAIT;
        end

        if (rst || (state == FLUSH) || excp_req) begin
            stall = 6'b000000;
        end else if (stallreq_ex) begin
            stall = 6'b001111;
        end else if (stallreq_id) begin
            stall = 6'b000111;
        end

        wait_inc_c = stallreq_ex && !excp_req && (state != FLUSH);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush  <= 1'b0;
            new_pc <= 32'h0000_0000;
        end else begin
            flush <= (next_state == FLUSH);
            if (excp_req) begin
                new_pc <= excp_pc;
            end
        end
    end

    // Watchdog: counts consecutive EX-stall cycles, parks at MAX_STALL once tripped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt      <= '0;
            stall_timeout <= 1'b0;
        end else if (wait_inc_c) begin
            if (wait_cnt == WAIT_W'(MAX_STALL - 1)) begin
                wait_cnt      <= WAIT_W'(MAX_STALL);
                stall_timeout <= 1'b1;
            end else if (wait_cnt != WAIT_W'(MAX_STALL)) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end
        end else begin
            wait_cnt <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if ((stall != 6'b000000) && (stall_cycles != {CNT_W{1'b1}})) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios plus randomized traffic against a cycle model.
module tb_pipe_ctrl;

    localparam int unsigned MAX_STALL = 4;
    localparam int unsigned CNT_W     = 3;
    localparam int          CNT_MAX   = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             stallreq_id;
    logic             stallreq_ex;
    logic             excp_req;
    logic [31:0]      excp_pc;
    logic [5:0]       stall;
    logic             flush;
    logic [31:0]      new_pc;
    logic             stall_timeout;
    logic [CNT_W-1:0] stall_cycles;

    int checks = 0;
    int errors = 0;

    pipe_ctrl #(.MAX_STALL(MAX_STALL), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .stallreq_id  (stallreq_id),
        .stallreq_ex  (stallreq_ex),
        .excp_req     (excp_req),
        .excp_pc      (excp_pc),
        .stall        (stall),
        .flush        (flush),
        .new_pc       (new_pc),
        .stall_timeout(stall_timeout),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    // Apply inputs in the low phase and let combinational outputs settle.
    task automatic drive(input logic id, input logic ex, input logic e, input logic [31:0] pc);
        @(negedge clk);
        stallreq_id = id;
        stallreq_ex = ex;
        excp_req    = e;
        excp_pc     = pc;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        stallreq_id = 1'b0; stallreq_ex = 1'b0; excp_req = 1'b0; excp_pc = 32'h0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        stallreq_id = 1'b1; stallreq_ex = 1'b1; excp_req = 1'b1; excp_pc = 32'h1234_5678;
        #1;
        checks++; if (stall !== 6'b000000) begin errors++; $display("FAIL reset_stall got=%b exp=000000", stall); end
        tick();
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL reset_flush got=%b exp=0", flush); end
        checks++; if (new_pc !== 32'h0) begin errors++; $display("FAIL reset_new_pc got=%h exp=0", new_pc); end
        checks++; if (stall_cycles !== '0) begin errors++; $display("FAIL reset_cycles got=%0d exp=0", stall_cycles); end
        checks++; if (stall_timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got=%b exp=0", stall_timeout); end
        @(negedge clk);
        excp_req = 1'b0;
        rst = 1'b0;
        #1;
        checks++; if (stall !== 6'b001111) begin errors++; $display("FAIL reset_release_stall got=%b exp=001111", stall); end
    endtask

    task automatic test_id_stall();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, 1'b0, 32'h0);
            checks++; if (stall !== 6'b000111) begin errors++; $display("FAIL id_stall[%0d] got=%b exp=000111", i, stall); end
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        checks++; if (stall !== 6'b000000) begin errors++; $display("FAIL id_release got=%b exp=000000", stall); end
        tick();
        checks++; if (stall_cycles !== CNT_W'(2)) begin errors++; $display("FAIL id_cycles got=%0d exp=2", stall_cycles); end
    endtask

    task automatic test_ex_and_id();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b0, 32'h0);
            checks++; if (stall !== 6'b001111) begin errors++; $display("FAIL ex_id_stall[%0d] got=%b exp=001111", i, stall); end
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        checks++; if (stall_cycles !== CNT_W'(3)) begin errors++; $display("FAIL ex_id_cycles got=%0d exp=3", stall_cycles); end
        checks++; if (stall_timeout !== 1'b0) begin errors++; $display("FAIL ex_id_timeout got=%b exp=0", stall_timeout); end
    endtask

    task automatic test_exception();
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        drive(1'b0, 1'b1, 1'b1, 32'hBFC0_0380);
        checks++; if (stall !== 6'b000000) begin errors++; $display("FAIL excp_stall got=%b exp=000000", stall); end
        tick();
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL excp_flush got=%b exp=1", flush); end
        checks++; if (new_pc !== 32'hBFC0_0380) begin errors++; $display("FAIL excp_new_pc got=%h exp=bfc00380", new_pc); end
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        checks++; if (stall !== 6'b000000) begin errors++; $display("FAIL flush_cycle_stall got=%b exp=000000", stall); end
        tick();
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL flush_end got=%b exp=0", flush); end
        checks++; if (new_pc !== 32'hBFC0_0380) begin errors++; $display("FAIL new_pc_hold got=%h exp=bfc00380", new_pc); end
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        checks++; if (stall !== 6'b001111) begin errors++; $display("FAIL after_flush_stall got=%b exp=001111", stall); end
        // Exception back-to-back: second request during the flush cycle extends it.
        drive(1'b0, 1'b0, 1'b1, 32'h8000_0180);
        tick();
        drive(1'b0, 1'b0, 1'b1, 32'h8000_0200);
        tick();
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL double_flush got=%b exp=1", flush); end
        checks++; if (new_pc !== 32'h8000_0200) begin errors++; $display("FAIL double_new_pc got=%h exp=80000200", new_pc); end
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL double_flush_end got=%b exp=0", flush); end
    endtask

    task automatic test_timeout();
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            drive(1'b0, 1'b1, 1'b0, 32'h0);
            tick();
            checks++;
            if (stall_timeout !== (i >= 4)) begin
                errors++; $display("FAIL timeout_edge[%0d] got=%b exp=%b", i, stall_timeout, (i >= 4));
            end
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        checks++; if (stall_timeout !== 1'b1) begin errors++; $display("FAIL timeout_sticky got=%b exp=1", stall_timeout); end
        checks++; if (stall !== 6'b000000) begin errors++; $display("FAIL timeout_release_stall got=%b exp=000000", stall); end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int i = 1; i <= 10; i++) begin
            drive(1'b1, 1'b0, 1'b0, 32'h0);
            tick();
            checks++;
            if (int'(stall_cycles) !== ((i > CNT_MAX) ? CNT_MAX : i)) begin
                errors++; $display("FAIL sat_cycles[%0d] got=%0d exp=%0d", i, stall_cycles, (i > CNT_MAX) ? CNT_MAX : i);
            end
        end
    endtask

    // Cycle model: pending flush, consecutive EX-stall run length, sticky timeout, counter.
    task automatic test_random();
        bit          m_flush = 1'b0;
        int          m_run   = 0;
        bit          m_to    = 1'b0;
        int          m_cnt   = 0;
        logic [31:0] m_pc    = 32'h0;
        logic [5:0]  m_stall;
        logic        id, ex, e;
        logic [31:0] pc;
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            if ($urandom_range(99) < 3) begin
                rst = 1'b1;
                #1;
                checks++;
                if (flush !== 1'b0 || new_pc !== 32'h0 || stall_timeout !== 1'b0 || stall_cycles !== '0 || stall !== 6'b0) begin
                    errors++; $display("FAIL rand_async_reset cyc=%0d flush=%b pc=%h to=%b cnt=%0d stall=%b", cyc, flush, new_pc, stall_timeout, stall_cycles, stall);
                end
                m_flush = 1'b0; m_run = 0; m_to = 1'b0; m_cnt = 0; m_pc = 32'h0;
                #1;
                rst = 1'b0;
            end
            id = ($urandom_range(99) < 40);
            ex = ($urandom_range(99) < 45);
            e  = ($urandom_range(99) < 12);
            pc = $urandom;
            stallreq_id = id; stallreq_ex = ex; excp_req = e; excp_pc = pc;
            #1;
            if (m_flush || e)  m_stall = 6'b000000;
            else if (ex)       m_stall = 6'b001111;
            else if (id)       m_stall = 6'b000111;
            else               m_stall = 6'b000000;
            checks++;
            if (stall !== m_stall) begin
                errors++; $display("FAIL rand_stall cyc=%0d got=%b exp=%b", cyc, stall, m_stall);
            end
            if (m_stall != 6'b0 && m_cnt < CNT_MAX) m_cnt++;
            if (ex && !e && !m_flush) begin
                m_run++;
                if (m_run >= int'(MAX_STALL)) m_to = 1'b1;
            end else begin
                m_run = 0;
            end
            m_flush = e;
            if (e) m_pc = pc;
            tick();
            checks++;
            if (flush !== m_flush || new_pc !== m_pc || stall_timeout !== m_to || int'(stall_cycles) !== m_cnt) begin
                errors++;
                $display("FAIL rand_regs cyc=%0d flush=%b/%b pc=%h/%h to=%b/%b cnt=%0d/%0d",
                         cyc, flush, m_flush, new_pc, m_pc, stall_timeout, m_to, stall_cycles, m_cnt);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        stallreq_id = 1'b0; stallreq_ex = 1'b0; excp_req = 1'b0; excp_pc = 32'h0;
        test_reset();
        test_id_stall();
        test_ex_and_id();
        test_exception();
        test_timeout();
        test_saturate();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
